// File: rtl/mdu_sequencer.sv
// Sequencer for RISC-V M-extension ops around an external multi-cycle mul/div unit.
// Define MDU_RESULT_CACHE_EN to keep the last MCycle result pair for back-to-back reuse.
module mdu_sequencer #(
    parameter int width = 32
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             Req,
    input  logic [2:0]       Funct3,
    input  logic [width-1:0] RS1,
    input  logic [width-1:0] RS2,
    input  logic             Flush,
    output logic             Stall,
    output logic [width-1:0] Result,
    output logic             ResultValid,
    output logic             MC_Start,
    output logic [1:0]       MC_Op,
    output logic [width-1:0] MC_Op1,
    output logic [width-1:0] MC_Op2,
    input  logic [width-1:0] MC_Result1,
    input  logic [width-1:0] MC_Result2,
    input  logic             MC_Busy
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LAUNCH = 3'd1;
    localparam logic [2:0] WAIT   = 3'd2;
    localparam logic [2:0] DRAIN  = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    localparam logic [width-1:0] INT_MIN = {1'b1, {(width-1){1'b0}}};

    logic [2:0]       state_reg, state_next;
    logic [2:0]       funct3_reg;
    logic [1:0]       op_reg;
    logic [width-1:0] op1_reg, op2_reg;
    logic [width-1:0] result_reg, result_next;

    function automatic logic [1:0] map_op(input logic [2:0] f3);
        map_op = {f3[2], f3[2] ? f3[0] : f3[1]};
    endfunction

    // MULHSU is run as an unsigned multiply; the signed RS1 is fixed up here.
    function automatic logic [width-1:0] select_result(
        input logic [2:0]       f3,
        input logic [width-1:0] lo,
        input logic [width-1:0] hi,
        input logic             a_msb,
        input logic [width-1:0] b
    );
        if (f3[2])
            select_result = f3[1] ? hi : lo;
        else begin
            case (f3[1:0])
                2'b00:   select_result = lo;
                2'b10:   select_result = hi - (a_msb ? b : '0);
                default: select_result = hi;
            endcase
        end
    endfunction

    logic             accept;
    logic             div_zero, div_ovf, is_special;
    logic [width-1:0] special_result;
    logic             mc_done;
    logic             cache_hit;
    logic [width-1:0] cache_result;

    assign accept     = (state_reg == IDLE) && Req && !Flush;
    assign div_zero   = (RS2 == '0);
    assign div_ovf    = !Funct3[0] && (RS1 == INT_MIN) && (RS2 == '1);
    assign is_special = Funct3[2] && (div_zero || div_ovf);
    assign special_result = div_zero ? (Funct3[1] ? RS1 : '1)
                                     : (Funct3[1] ? '0 : INT_MIN);
    assign mc_done    = (state_reg == WAIT) && !MC_Busy && !Flush;

`ifdef MDU_RESULT_CACHE_EN
    logic             cache_valid_reg;
    logic [1:0]       cache_op_reg;
    logic [width-1:0] cache_a_reg, cache_b_reg, cache_lo_reg, cache_hi_reg;

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            cache_valid_reg <= 1'b0;
            cache_op_reg    <= '0;
            cache_a_reg     <= '0;
            cache_b_reg     <= '0;
            cache_lo_reg    <= '0;
            cache_hi_reg    <= '0;
        end else if (mc_done) begin
            cache_valid_reg <= 1'b1;
            cache_op_reg    <= op_reg;
            cache_a_reg     <= op1_reg;
            cache_b_reg     <= op2_reg;
            cache_lo_reg    <= MC_Result1;
            cache_hi_reg    <= MC_Result2;
        end
    end

    assign cache_hit = cache_valid_reg && (cache_op_reg == map_op(Funct3)) &&
                       (cache_a_reg == RS1) && (cache_b_reg == RS2);
    assign cache_result = select_result(Funct3, cache_lo_reg, cache_hi_reg,
                                        RS1[width-1], RS2);
`else
    assign cache_hit    = 1'b0;
    assign cache_result = '0;
`endif

    always_comb begin
        state_next  = state_reg;
        result_next = result_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (is_special) begin
                        result_next = special_result;
                        state_next  = DONE;
                    end else if (cache_hit) begin
                        result_next = cache_result;
                        state_next  = DONE;
                    end else
                        state_next = LAUNCH;
                end
            end
            LAUNCH: state_next = Flush ? DRAIN : WAIT;
            WAIT: begin
                if (Flush)
                    state_next = DRAIN;
                else if (!MC_Busy) begin
                    result_next = select_result(funct3_reg, MC_Result1, MC_Result2,
                                                op1_reg[width-1], op2_reg);
                    state_next  = DONE;
                end
            end
            DRAIN:   if (!MC_Busy) state_next = IDLE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand registers double as the MC_Op* outputs, so they stay put until the next accept.
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state_reg  <= IDLE;
            result_reg <= '0;
            funct3_reg <= '0;
            op_reg     <= '0;
            op1_reg    <= '0;
            op2_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            result_reg <= result_next;
            if (accept) begin
                funct3_reg <= Funct3;
                op_reg     <= map_op(Funct3);
                op1_reg    <= RS1;
                op2_reg    <= RS2;
            end
        end
    end

    assign Stall       = (state_reg == LAUNCH) || (state_reg == WAIT) ||
                         (state_reg == DRAIN) || accept;
    assign ResultValid = (state_reg == DONE) && !Flush;
    assign MC_Start    = (state_reg == LAUNCH);
    assign Result      = result_reg;
    assign MC_Op       = op_reg;
    assign MC_Op1      = op1_reg;
    assign MC_Op2      = op2_reg;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Testbench for mdu_sequencer: behavioural multi-cycle unit, vector table, random ops, flush/reset corners.
module tb_mdu_sequencer;

`ifdef MDU_RESULT_CACHE_EN
    localparam bit CACHE_ON = 1'b1;
`else
    localparam bit CACHE_ON = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RESETn;
    logic        Req;
    logic [2:0]  Funct3;
    logic [31:0] RS1, RS2;
    logic        Flush;
    logic        Stall;
    logic [31:0] Result;
    logic        ResultValid;
    logic        MC_Start;
    logic [1:0]  MC_Op;
    logic [31:0] MC_Op1, MC_Op2;
    logic [31:0] MC_Result1, MC_Result2;
    logic        MC_Busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    mdu_sequencer #(.width(32)) dut (
        .CLK(CLK), .RESETn(RESETn), .Req(Req), .Funct3(Funct3), .RS1(RS1), .RS2(RS2),
        .Flush(Flush), .Stall(Stall), .Result(Result), .ResultValid(ResultValid),
        .MC_Start(MC_Start), .MC_Op(MC_Op), .MC_Op1(MC_Op1), .MC_Op2(MC_Op2),
        .MC_Result1(MC_Result1), .MC_Result2(MC_Result2), .MC_Busy(MC_Busy)
    );

    // ---------------- behavioural multi-cycle unit ----------------
    int          mc_lat = 1;
    int          mc_cnt;
    logic [31:0] mc_lo, mc_hi;

    function automatic logic [63:0] mc_compute(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        logic [31:0] q, r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        case (op)
            2'd0: return sa * sb;
            2'd1: return {32'b0, a} * {32'b0, b};
            2'd2: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
                q = int'(a) / int'(b);
                r = int'(a) % int'(b);
                return {r, q};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    always @(posedge CLK) begin
        if (!RESETn) begin
            mc_cnt <= 0;
        end else if (MC_Start) begin
            mc_cnt <= mc_lat - 1;
            {mc_hi, mc_lo} <= mc_compute(MC_Op, MC_Op1, MC_Op2);
        end else if (mc_cnt > 0) begin
            mc_cnt <= mc_cnt - 1;
        end
    end

    assign MC_Busy    = MC_Start || (mc_cnt != 0);
    assign MC_Result1 = mc_lo;
    assign MC_Result2 = mc_hi;

    // ---------------- architectural reference model ----------------
    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, sp;
        logic [63:0] up;
        logic ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
        case (f3)
            3'd0: begin up = {32'b0, a} * {32'b0, b}; return up[31:0]; end
            3'd1: begin sp = sa * sb; return sp[63:32]; end
            3'd2: begin sp = sa * $signed({32'b0, b}); return sp[63:32]; end
            3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (ovf) return 32'h80000000;
                return int'(a) / int'(b);
            end
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                return int'(a) % int'(b);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit ref_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        return (f3 >= 3'd4) && ((b == 0) ||
               ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF));
    endfunction

    function automatic logic [1:0] ref_op(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd1: return 2'd0;
            3'd2, 3'd3: return 2'd1;
            3'd4, 3'd6: return 2'd2;
            default:    return 2'd3;
        endcase
    endfunction

    // Last completed MCycle operation (only consulted when the cache is built in)
    bit          c_valid = 1'b0;
    logic [1:0]  c_op;
    logic [31:0] c_a, c_b;

    function automatic bit ref_hit(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        return CACHE_ON && c_valid && c_op == ref_op(f3) && c_a == a && c_b == b;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input int lat, input logic [31:0] exp_res,
                          input bit exp_fast);
        logic [31:0] res;
        int latency, starts;
        bit got;
        @(negedge CLK);
        Funct3 = f3; RS1 = a; RS2 = b; mc_lat = lat; Req = 1'b1;
        #1 check({name, "_stall_req"}, Stall, 1);
        @(posedge CLK);
        #1 Req = 1'b0;
        got = 0; latency = 0; starts = 0; res = '0;
        for (int i = 1; i <= 40 && !got; i++) begin
            @(negedge CLK);
            if (MC_Start) starts++;
            if (ResultValid) begin
                got = 1; latency = i; res = Result;
            end
        end
        $display("op %s f3=%0d rs1=%h rs2=%h lat=%0d -> result=%h latency=%0d starts=%0d",
                 name, f3, a, b, lat, res, latency, starts);
        check({name, "_valid"}, got, 1);
        check({name, "_result"}, res, exp_res);
        check({name, "_latency"}, latency, exp_fast ? 1 : lat + 2);
        check({name, "_starts"}, starts, exp_fast ? 0 : 1);
        if (!exp_fast) begin
            c_valid = 1'b1; c_op = ref_op(f3); c_a = a; c_b = b;
        end
    endtask

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [31:0] a, b;
        int          lat;
        logic [31:0] exp;
        bit          fast;
    } vec_t;

    vec_t vecs[11];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rv, stall_low, starts_seen;
        logic busy_at_low;
        logic [2:0] f3;
        logic [31:0] a, b;
        int lat;

        vecs[0]  = '{"mul_neg3x7",   3'd0, 32'hFFFFFFFD, 32'd7,        3, 32'hFFFFFFEB, 1'b0};
        vecs[1]  = '{"mulhsu_m1x2",  3'd2, 32'hFFFFFFFF, 32'd2,        2, 32'hFFFFFFFF, 1'b0};
        vecs[2]  = '{"mulhu_m1x2",   3'd3, 32'hFFFFFFFF, 32'd2,        2, 32'h00000001, CACHE_ON};
        vecs[3]  = '{"div_ovf",      3'd4, 32'h80000000, 32'hFFFFFFFF, 3, 32'h80000000, 1'b1};
        vecs[4]  = '{"remu_by0",     3'd7, 32'd5,        32'd0,        3, 32'd5,        1'b1};
        vecs[5]  = '{"div_m7_2",     3'd4, 32'hFFFFFFF9, 32'd2,        4, 32'hFFFFFFFD, 1'b0};
        vecs[6]  = '{"rem_m7_2",     3'd6, 32'hFFFFFFF9, 32'd2,        4, 32'hFFFFFFFF, CACHE_ON};
        vecs[7]  = '{"divu_100_7",   3'd5, 32'd100,      32'd7,        1, 32'd14,       1'b0};
        vecs[8]  = '{"mulh_min2",    3'd1, 32'h80000000, 32'h80000000, 2, 32'h40000000, 1'b0};
        vecs[9]  = '{"rem_ovf",      3'd6, 32'h80000000, 32'hFFFFFFFF, 2, 32'd0,        1'b1};
        vecs[10] = '{"div_by0",      3'd4, 32'd5,        32'd0,        2, 32'hFFFFFFFF, 1'b1};

        RESETn = 1'b0; Req = 1'b0; Flush = 1'b0; Funct3 = '0; RS1 = '0; RS2 = '0;
        repeat (3) @(posedge CLK);
        #1 RESETn = 1'b1;
        @(negedge CLK);
        check("rst_stall", Stall, 0);
        check("rst_valid", ResultValid, 0);
        check("rst_start", MC_Start, 0);
        check("rst_result", Result, 0);
        check("rst_op", MC_Op, 0);
        check("rst_op1", MC_Op1, 0);
        check("rst_op2", MC_Op2, 0);

        for (int i = 0; i < 11; i++)
            run_op(vecs[i].name, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].lat, vecs[i].exp, vecs[i].fast);

        // Flush two cycles after launch of a long DIVU: drain, no result
        @(negedge CLK);
        Funct3 = 3'd5; RS1 = 32'd1000; RS2 = 32'd3; mc_lat = 6; Req = 1'b1;
        @(posedge CLK);
        #1 Req = 1'b0;
        rv = 0; stall_low = 0; busy_at_low = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge CLK);
            if (c == 3) Flush = 1'b1;
            if (ResultValid) rv++;
            if (!Stall && stall_low == 0) begin
                stall_low = c; busy_at_low = MC_Busy;
            end
            if (c == 3) begin
                @(posedge CLK);
                #1 Flush = 1'b0;
            end
        end
        $display("op flush_divu rs1=%h rs2=%h -> valids=%0d stall_low_cycle=%0d", 32'd1000, 32'd3, rv, stall_low);
        check("flush_no_valid", rv, 0);
        check("flush_stall_low_cycle", stall_low, 8);
        check("flush_busy_at_release", busy_at_low, 0);
        run_op("mul_3x4", 3'd0, 32'd3, 32'd4, 2, 32'd12, 1'b0);

        // Flush together with Req in IDLE: nothing accepted
        @(negedge CLK);
        Funct3 = 3'd0; RS1 = 32'd9; RS2 = 32'd9; mc_lat = 1; Req = 1'b1; Flush = 1'b1;
        #1 check("idle_flush_stall", Stall, 0);
        @(posedge CLK);
        #1 begin Req = 1'b0; Flush = 1'b0; end
        rv = 0; starts_seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            if (ResultValid) rv++;
            if (MC_Start) starts_seen++;
        end
        $display("op idle_flush_req -> valids=%0d starts=%0d", rv, starts_seen);
        check("idle_flush_no_valid", rv, 0);
        check("idle_flush_no_start", starts_seen, 0);

        // Flush during DONE suppresses ResultValid
        @(negedge CLK);
        Funct3 = 3'd4; RS1 = 32'd9; RS2 = 32'd0; Req = 1'b1;
        @(posedge CLK);
        #1 begin Req = 1'b0; Flush = 1'b1; end
        @(negedge CLK);
        $display("op done_flush div 9/0 -> valid=%0d", ResultValid);
        check("done_flush_valid", ResultValid, 0);
        @(posedge CLK);
        #1 Flush = 1'b0;
        rv = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            if (ResultValid) rv++;
        end
        check("done_flush_no_late_valid", rv, 0);

        // Reset during WAIT
        @(negedge CLK);
        Funct3 = 3'd5; RS1 = 32'd1000; RS2 = 32'd3; mc_lat = 6; Req = 1'b1;
        @(posedge CLK);
        #1 Req = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        @(negedge CLK);
        RESETn = 1'b0;
        @(posedge CLK);
        #1 RESETn = 1'b1;
        c_valid = 1'b0;
        @(negedge CLK);
        $display("op reset_in_wait -> stall=%0d valid=%0d start=%0d result=%h", Stall, ResultValid, MC_Start, Result);
        check("wrst_stall", Stall, 0);
        check("wrst_valid", ResultValid, 0);
        check("wrst_start", MC_Start, 0);
        check("wrst_result", Result, 0);
        check("wrst_op", MC_Op, 0);
        check("wrst_op1", MC_Op1, 0);
        check("wrst_op2", MC_Op2, 0);
        rv = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            if (ResultValid) rv++;
        end
        check("wrst_no_valid", rv, 0);
        run_op("divu_100_7_post_rst", 3'd5, 32'd100, 32'd7, 2, 32'd14, 1'b0);

        // Randomized ops against the reference model
        for (int i = 0; i < 30; i++) begin
            f3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 9))
                0: a = 32'd0;
                1: a = 32'h80000000;
                2: a = 32'hFFFFFFFF;
                3: a = $urandom_range(0, 20);
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 9))
                0, 1: b = 32'd0;
                2: b = 32'hFFFFFFFF;
                3: b = $urandom_range(1, 20);
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) begin
                a = 32'h80000000; b = 32'hFFFFFFFF;
            end
            lat = $urandom_range(1, 4);
            run_op("rand", f3, a, b, lat, ref_result(f3, a, b),
                   ref_special(f3, a, b) || ref_hit(f3, a, b));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
